// File: rtl/cmd_frontend.sv
// BRAM datapath command front-end: synchronises the GPIO command/operand registers,
// issues one command per start rise over valid/ready and captures the datapath result.

module cmd_frontend_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset)
    if (!reset) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};

  assign q = ff[STAGES-1];
endmodule

module cmd_frontend #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] ADR_BASE    = 32'd0,
  parameter logic [31:0] ADR_STRIDE  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  gpio_cmdreg,
  input  logic [7:0]  gpio_mult,
  input  logic [7:0]  gpio_offset,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [31:0] cmd_adr,
  output logic [7:0]  cmd_mult,
  output logic [7:0]  cmd_offset,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic [31:0] gpio_rd,
  output logic [2:0]  gpio_status
);
  localparam int GPIO_W = 24;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [GPIO_W-1:0] gpio_a, gpio_s;
  logic [7:0] cmd_s, mult_s, offset_s;
  logic       start_s, start_q, rise, busy, done, overrun;
  logic       unused_cmd_bits;

  assign gpio_a = {gpio_cmdreg, gpio_mult, gpio_offset};

  // Every GPIO bit gets its own synchroniser chain of equal depth, so fields
  // written before start are already settled when the start rise is seen.
  genvar i;
  generate
    for (i = 0; i < GPIO_W; i++) begin : g_sync
      cmd_frontend_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (gpio_a[i]),
        .q    (gpio_s[i])
      );
    end
  endgenerate

  assign {cmd_s, mult_s, offset_s} = gpio_s;
  assign start_s         = cmd_s[0];
  assign rise            = start_s & ~start_q;
  assign unused_cmd_bits = ^cmd_s[2:1];

  // start_q clears on reset so a start held across reset release looks like a rise.
  always_ff @(posedge clk or negedge reset)
    if (!reset) start_q <= 1'b0;
    else        start_q <= start_s;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise)      state_nxt = ISSUE;
      ISSUE:   if (cmd_ready) state_nxt = WAIT;
      WAIT:    if (res_valid) state_nxt = DONE;
      DONE:    if (!start_s)  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign cmd_valid   = (state == ISSUE);
  assign busy        = (state == ISSUE) | (state == WAIT);
  assign gpio_status = {overrun, done, busy};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_op     <= '0;
      cmd_adr    <= '0;
      cmd_mult   <= '0;
      cmd_offset <= '0;
      gpio_rd    <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (state == IDLE && rise) begin
        cmd_op     <= cmd_s[7:6];
        cmd_adr    <= ADR_BASE + 32'(cmd_s[5:3]) * ADR_STRIDE;
        cmd_mult   <= mult_s;
        cmd_offset <= offset_s;
        done       <= 1'b0;
        overrun    <= 1'b0;
      end
      // A second start while a command is in flight is flagged, never queued.
      if (busy && rise) overrun <= 1'b1;
      if (state == WAIT && res_valid) begin
        gpio_rd <= res_data;
        done    <= 1'b1;
      end
    end
  end
endmodule
